// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - in-order pipeline hazard controller (load-use, branch flush, memory wait)
//
// Purpose: resolves pipeline hazards for a 5-stage in-order core. The priority order is
// memory stall first, then taken branch/jump redirect, then load-use bubble. A small FSM
// tracks long memory waits and traps into a sticky error state on timeout.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   rs1_decode, rs2_decode        ID-stage source registers
//   uses_rs1_decode/rs2_decode    ID instruction actually reads rs1/rs2
//   rd_execute, memRead_execute   EX-stage destination register and load flag
//   branch_taken_execute          EX resolved a taken branch/jump
//   target_PC_execute             redirect target from EX
//   mem_req_memory, mem_ready     MEM-stage data access and memory completion
//   stall_front, stall_back       hold PC+IF/ID, hold ID/EX+EX/MEM
//   bubble_execute, flush_decode  NOP into ID/EX, squash IF/ID
//   redirect_valid, redirect_PC   PC load strobe and value (0 when not redirecting)
//   ctrl_state                    FSM state (RUN/MEM_WAIT/HALT_ERR)
//   mem_timeout                   sticky memory timeout error
//   stall_cycles, flush_events    saturating event counters

module pipeline_hazard_controller #(
  parameter int ADDRESS_BITS = 12,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4:0]              rs1_decode,
  input  logic [4:0]              rs2_decode,
  input  logic                    uses_rs1_decode,
  input  logic                    uses_rs2_decode,
  input  logic [4:0]              rd_execute,
  input  logic                    memRead_execute,
  input  logic                    branch_taken_execute,
  input  logic [ADDRESS_BITS-1:0] target_PC_execute,
  input  logic                    mem_req_memory,
  input  logic                    mem_ready,
  output logic                    stall_front,
  output logic                    stall_back,
  output logic                    bubble_execute,
  output logic                    flush_decode,
  output logic                    redirect_valid,
  output logic [ADDRESS_BITS-1:0] redirect_PC,
  output logic [1:0]              ctrl_state,
  output logic                    mem_timeout,
  output logic [15:0]             stall_cycles,
  output logic [15:0]             flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT_ERR = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        memstall;
  logic        loaduse;

  assign ctrl_state = state;

  // Hazard conditions; x0 is never a real dependency.
  always_comb begin
    memstall = mem_req_memory && !mem_ready;
    loaduse  = memRead_execute && (rd_execute != 5'd0) &&
               ((uses_rs1_decode && (rs1_decode == rd_execute)) ||
                (uses_rs2_decode && (rs2_decode == rd_execute)));
  end

  // Control strobes: exactly one action per cycle, all forced off during reset.
  always_comb begin
    stall_front    = 1'b0;
    stall_back     = 1'b0;
    bubble_execute = 1'b0;
    flush_decode   = 1'b0;
    redirect_valid = 1'b0;
    redirect_PC    = '0;
    if (!reset) begin
      case (state)
        RUN, MEM_WAIT: begin
          if (memstall) begin
            stall_front = 1'b1;
            stall_back  = 1'b1;
          end else if (branch_taken_execute) begin
            // The ID instruction is squashed, so any load-use on it is moot.
            redirect_valid = 1'b1;
            redirect_PC    = target_PC_execute;
            flush_decode   = 1'b1;
            bubble_execute = 1'b1;
          end else if (loaduse) begin
            stall_front    = 1'b1;
            bubble_execute = 1'b1;
          end
        end
        HALT_ERR: begin
          stall_front = 1'b1;
          stall_back  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= 16'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      if (stall_front && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (redirect_valid && (flush_events != 16'hFFFF))
        flush_events <= flush_events + 16'd1;

      case (state)
        RUN: begin
          if (memstall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end
        end
        MEM_WAIT: begin
          // A dropped request counts as completion, same as mem_ready.
          if (memstall) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt == TIMEOUT_LAST) begin
              state       <= HALT_ERR;
              mem_timeout <= 1'b1;
            end
          end else begin
            state    <= RUN;
            wait_cnt <= 16'd0;
          end
        end
        HALT_ERR: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
//
// The driver applies one directed vector per cycle and queues its hand-computed
// expectation; the monitor pops and compares on the following falling edge.
// Expected word packing: {stall_front, stall_back, bubble_execute, flush_decode,
// redirect_valid, redirect_PC[11:0], ctrl_state[1:0], mem_timeout, stall_cycles, flush_events}.

module tb_pipeline_hazard_controller;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_decode;
  logic [4:0]  rs2_decode;
  logic        uses_rs1_decode;
  logic        uses_rs2_decode;
  logic [4:0]  rd_execute;
  logic        memRead_execute;
  logic        branch_taken_execute;
  logic [11:0] target_PC_execute;
  logic        mem_req_memory;
  logic        mem_ready;
  logic        stall_front;
  logic        stall_back;
  logic        bubble_execute;
  logic        flush_decode;
  logic        redirect_valid;
  logic [11:0] redirect_PC;
  logic [1:0]  ctrl_state;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;

  pipeline_hazard_controller #(
    .ADDRESS_BITS(12),
    .MEM_TIMEOUT (4)
  ) dut (
    .clock               (clk),
    .reset               (reset),
    .rs1_decode          (rs1_decode),
    .rs2_decode          (rs2_decode),
    .uses_rs1_decode     (uses_rs1_decode),
    .uses_rs2_decode     (uses_rs2_decode),
    .rd_execute          (rd_execute),
    .memRead_execute     (memRead_execute),
    .branch_taken_execute(branch_taken_execute),
    .target_PC_execute   (target_PC_execute),
    .mem_req_memory      (mem_req_memory),
    .mem_ready           (mem_ready),
    .stall_front         (stall_front),
    .stall_back          (stall_back),
    .bubble_execute      (bubble_execute),
    .flush_decode        (flush_decode),
    .redirect_valid      (redirect_valid),
    .redirect_PC         (redirect_PC),
    .ctrl_state          (ctrl_state),
    .mem_timeout         (mem_timeout),
    .stall_cycles        (stall_cycles),
    .flush_events        (flush_events)
  );

  typedef struct {
    string       name;
    logic [51:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are stable half a cycle after the driver changes inputs.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      chk_t        c;
      logic [51:0] act;
      c   = sb_q.pop_front();
      act = {stall_front, stall_back, bubble_execute, flush_decode, redirect_valid,
             redirect_PC, ctrl_state, mem_timeout, stall_cycles, flush_events};
      tests_run++;
      if (act !== c.exp) begin
        tests_failed++;
        $display("FAIL %s: got strobes=%b pc=%h st=%0d to=%b sc=%h fe=%h, expected strobes=%b pc=%h st=%0d to=%b sc=%h fe=%h",
                 c.name, act[51:47], act[46:35], act[34:33], act[32], act[31:16], act[15:0],
                 c.exp[51:47], c.exp[46:35], c.exp[34:33], c.exp[32], c.exp[31:16], c.exp[15:0]);
      end
    end
  end

  // One vector: inputs, then expected {sf,sb,bub,fl,rv}, redirect_PC, state, timeout, counters.
  task automatic vec(input string nm, input logic rst,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic mr, input logic br, input logic [11:0] tgt,
                     input logic mreq, input logic mrdy,
                     input logic [4:0] o, input logic [11:0] rpc, input logic [1:0] st,
                     input logic to, input logic [15:0] sc, input logic [15:0] fe);
    chk_t c;
    @(posedge clk);
    #1;
    reset                = rst;
    rs1_decode           = rs1;
    uses_rs1_decode      = u1;
    rs2_decode           = rs2;
    uses_rs2_decode      = u2;
    rd_execute           = rd;
    memRead_execute      = mr;
    branch_taken_execute = br;
    target_PC_execute    = tgt;
    mem_req_memory       = mreq;
    mem_ready            = mrdy;
    c.name = nm;
    c.exp  = {o, rpc, st, to, sc, fe};
    sb_q.push_back(c);
  endtask

  initial begin
    reset = 1'b1;
    rs1_decode = 5'd0; rs2_decode = 5'd0; uses_rs1_decode = 1'b0; uses_rs2_decode = 1'b0;
    rd_execute = 5'd0; memRead_execute = 1'b0; branch_taken_execute = 1'b0;
    target_PC_execute = 12'h000; mem_req_memory = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    //   name             rst rs1  u1 rs2  u2 rd   mr br tgt      mreq rdy  strobes   rpc      st  to sc        fe
    vec("reset_forced",   1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 12'h0A4, 1, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd0,  16'd0);
    vec("idle",           0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 0, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd0,  16'd0);
    vec("loaduse_rs1",    0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 12'h000, 0, 0, 5'b10100, 12'h000, 2'd0, 0, 16'd0,  16'd0);
    vec("loaduse_rd0",    0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 12'h000, 0, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd1,  16'd0);
    vec("loaduse_rs2",    0, 5'd3, 1, 5'd7, 1, 5'd7, 1, 0, 12'h000, 0, 0, 5'b10100, 12'h000, 2'd0, 0, 16'd1,  16'd0);
    vec("uses_off",       0, 5'd7, 0, 5'd0, 0, 5'd7, 1, 0, 12'h000, 0, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd2,  16'd0);
    vec("branch_vs_lu",   0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 12'h0A4, 0, 0, 5'b00111, 12'h0A4, 2'd0, 0, 16'd2,  16'd0);
    vec("after_branch",   0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h0A4, 0, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd2,  16'd1);
    vec("memwait_1",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd0, 0, 16'd2,  16'd1);
    vec("memwait_2",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd1, 0, 16'd3,  16'd1);
    vec("memwait_3",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd1, 0, 16'd4,  16'd1);
    vec("memwait_ready",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 1, 5'b00000, 12'h000, 2'd1, 0, 16'd5,  16'd1);
    vec("memwait_run",    0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 0, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd5,  16'd1);
    vec("stall_hides_br", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 12'h3C0, 1, 0, 5'b11000, 12'h000, 2'd0, 0, 16'd5,  16'd1);
    vec("br_on_ready",    0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 12'h3C0, 1, 1, 5'b00111, 12'h3C0, 2'd1, 0, 16'd6,  16'd1);
    vec("stall_hides_lu", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd0, 0, 16'd6,  16'd2);
    vec("noreq_complete", 0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 12'h000, 0, 0, 5'b10100, 12'h000, 2'd1, 0, 16'd7,  16'd2);
    vec("back_to_run",    0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 0, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd8,  16'd2);
    vec("timeout_1",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd0, 0, 16'd8,  16'd2);
    vec("timeout_2",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd1, 0, 16'd9,  16'd2);
    vec("timeout_3",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd1, 0, 16'd10, 16'd2);
    vec("timeout_4",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd1, 0, 16'd11, 16'd2);
    vec("halt_ignores_br",0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 12'h055, 1, 0, 5'b11000, 12'h000, 2'd2, 1, 16'd12, 16'd2);
    vec("halt_sticky",    0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 1, 5'b11000, 12'h000, 2'd2, 1, 16'd13, 16'd2);

    // Sit in HALT_ERR long enough to push stall_cycles past 16 bits.
    repeat (65600) @(posedge clk);
    vec("sat_hold",       0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 0, 0, 5'b11000, 12'h000, 2'd2, 1, 16'hFFFF, 16'd2);
    vec("sat_nowrap",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 0, 0, 5'b11000, 12'h000, 2'd2, 1, 16'hFFFF, 16'd2);
    vec("reset_in_halt",  1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 12'h111, 1, 0, 5'b00000, 12'h000, 2'd2, 1, 16'hFFFF, 16'd2);
    vec("after_reset",    0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 0, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd0,  16'd0);
    vec("mw_before_rst",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b11000, 12'h000, 2'd0, 0, 16'd0,  16'd0);
    vec("reset_in_mw",    1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 1, 0, 5'b00000, 12'h000, 2'd1, 0, 16'd1,  16'd0);
    vec("no_pending",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 12'h000, 0, 0, 5'b00000, 12'h000, 2'd0, 0, 16'd0,  16'd0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameters SHALL be: ADDRESS_BITS, default 12, PC width; MEM_TIMEOUT, default 16, the maximum number of memory-wait cycles before error (2..65535).
REQ-002 The block SHALL have a single clock domain; reset is synchronous and active-high.
REQ-003 Ports SHALL be, in order:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- rs1_decode, rs2_decode  in  5 each  source registers in ID
- uses_rs1_decode, uses_rs2_decode  in  1 each  the ID instruction reads rs1/rs2
- rd_execute  in  5  destination register in EX
- memRead_execute  in  1  the EX instruction is a load
- branch_taken_execute  in  1  EX resolved a taken branch/jump
- target_PC_execute  in  ADDRESS_BITS  redirect target
- mem_req_memory  in  1  the MEM instruction accesses data memory
- mem_ready  in  1  data memory completes this cycle
- stall_front  out  1  hold PC and IF/ID
- stall_back  out  1  hold ID/EX and EX/MEM
- bubble_execute  out  1  load NOP into ID/EX
- flush_decode  out  1  squash IF/ID
- redirect_valid  out  1  PC load strobe
- redirect_PC  out  ADDRESS_BITS  PC load value
- ctrl_state  out  2  FSM state
- mem_timeout  out  1  sticky error
- stall_cycles  out  16  saturating count
- flush_events  out  16  saturating count

Function
REQ-004 FSM states SHALL be RUN=2'd0, MEM_WAIT=2'd1 and HALT_ERR=2'd2; 2'd3 SHALL be unreachable and SHALL go to RUN on the next clock.
REQ-005 Condition memstall SHALL be mem_req_memory && !mem_ready, evaluated combinationally in RUN and MEM_WAIT.
REQ-006 Condition loaduse SHALL be memRead_execute && rd_execute!=0 && ((uses_rs1_decode && rs1_decode==rd_execute) || (uses_rs2_decode && rs2_decode==rd_execute)).
REQ-007 Priority SHALL be memstall, then branch_taken_execute, then loaduse; at most one action SHALL apply per cycle.
REQ-008 Under memstall, stall_front=1 and stall_back=1, and bubble_execute, flush_decode and redirect_valid SHALL all be 0, even if a branch or load-use is present.
REQ-009 With no memstall and branch_taken_execute=1, the same cycle SHALL give redirect_valid=1, redirect_PC=target_PC_execute, flush_decode=1, bubble_execute=1, stall_front=0 and stall_back=0; loaduse SHALL be ignored because the ID instruction is squashed.
REQ-010 With no memstall, no branch and loaduse=1: stall_front=1, bubble_execute=1, stall_back=0; this gives exactly one bubble per load-use pair.
REQ-011 When redirect_valid=0, redirect_PC SHALL be 0.
REQ-012 In RUN, memstall SHALL cause next state MEM_WAIT and load wait_cnt with 1.
REQ-013 In MEM_WAIT with mem_ready=1:
- stall_front and stall_back SHALL be 0 that cycle, and branch/load-use SHALL be evaluated as in RUN;
- next state SHALL be RUN and wait_cnt SHALL clear.
REQ-014 In MEM_WAIT with memstall:
- wait_cnt SHALL increment;
- when wait_cnt==MEM_TIMEOUT-1, next state SHALL be HALT_ERR and mem_timeout SHALL be set to 1.
REQ-015 In MEM_WAIT, mem_req_memory=0 SHALL be treated as completion, per REQ-013.
REQ-016 HALT_ERR SHALL be left only by reset; in it stall_front=1, stall_back=1, all other strobes 0, and mem_timeout=1.
REQ-017 stall_cycles SHALL increment on every cycle with stall_front=1 and saturate at 16'hFFFF.
REQ-018 flush_events SHALL increment on every cycle with redirect_valid=1 and saturate at 16'hFFFF.
REQ-019 All control outputs SHALL be combinational from registered state and current inputs; ctrl_state, mem_timeout and both counters SHALL be registered.

Reset
REQ-020 While reset=1 at a clock edge, the following SHALL clear on that edge: ctrl_state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
REQ-021 While reset=1, stall_front, stall_back, bubble_execute, flush_decode and redirect_valid SHALL be forced to 0 regardless of inputs.
REQ-022 Reset asserted mid-MEM_WAIT or in HALT_ERR SHALL return the block to RUN on the next edge, with no pending stall retained.

Verification
REQ-023 Load-use: memRead_execute=1, rd_execute=5, rs1_decode=5, uses_rs1_decode=1 -> one cycle with stall_front=1 and bubble_execute=1; stall_cycles becomes 1. Repeat with rd_execute=0 -> no stall.
REQ-024 Branch vs load-use: branch_taken_execute=1, target_PC_execute=12'h0A4, with a load-use condition also true -> redirect_valid=1, redirect_PC=12'h0A4, flush_decode=1, bubble_execute=1, stall_front=0; flush_events becomes 1.
REQ-025 Memory wait: mem_req_memory=1 with mem_ready low for 3 cycles, then high -> ctrl_state goes RUN, MEM_WAIT, MEM_WAIT, MEM_WAIT, RUN; stall_front and stall_back are 1 for exactly 3 cycles.
REQ-026 Timeout: MEM_TIMEOUT=4, mem_ready held low -> HALT_ERR after 4 stalled cycles with mem_timeout=1, and it stays there; reset -> RUN with all counters 0.
REQ-027 Simultaneous events: memstall together with branch_taken_execute=1 -> no redirect while stalled; redirect issues in the mem_ready cycle.
REQ-028 Saturation: force 70000 stall cycles (bench or MEM_TIMEOUT=65535 with periodic ready) -> stall_cycles holds 16'hFFFF and does not wrap.
